// File: rtl/add_sub_align_pipe_if.sv
// add_sub_align_pipe_if
// Operand/result bundle for the add/sub ordering + alignment front end.
// Upstream side: i_valid/o_ready handshake plus operand fields
//   (i_op, i_sign_a/b, i_exp_a/b, i_man_a/b).
// Downstream side: o_valid/i_ready handshake plus ordered, aligned fields
//   (o_swap, o_eff_sub, o_sign, o_exp_max, o_man_max, o_man_min).
// Modports: slave = the pipeline itself, master = whoever drives operands
//   and consumes results (the environment around the block).
interface add_sub_align_pipe_if #(
  parameter int SIZE_EXP = 8,
  parameter int SIZE_MAN = 24
);
  logic                  i_valid;
  logic                  o_ready;
  logic                  i_op;
  logic                  i_sign_a;
  logic                  i_sign_b;
  logic [SIZE_EXP-1:0]   i_exp_a;
  logic [SIZE_EXP-1:0]   i_exp_b;
  logic [SIZE_MAN-1:0]   i_man_a;
  logic [SIZE_MAN-1:0]   i_man_b;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_swap;
  logic                  o_eff_sub;
  logic                  o_sign;
  logic [SIZE_EXP-1:0]   o_exp_max;
  logic [SIZE_MAN-1:0]   o_man_max;
  logic [SIZE_MAN+2:0]   o_man_min;

  modport slave (
    input  i_valid, i_op, i_sign_a, i_sign_b, i_exp_a, i_exp_b, i_man_a, i_man_b, i_ready,
    output o_ready, o_valid, o_swap, o_eff_sub, o_sign, o_exp_max, o_man_max, o_man_min
  );

  modport master (
    output i_valid, i_op, i_sign_a, i_sign_b, i_exp_a, i_exp_b, i_man_a, i_man_b, i_ready,
    input  o_ready, o_valid, o_swap, o_eff_sub, o_sign, o_exp_max, o_man_max, o_man_min
  );
endinterface

// File: rtl/add_sub_align_pipe.sv
// add_sub_align_pipe
// Two-stage FPU add/sub front end: stage 1 orders the operands by magnitude
// and resolves effective op / result sign; stage 2 right-aligns the smaller
// mantissa by the exponent difference, producing G, R and sticky bits.
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - synchronous active-low reset
//   bus      - add_sub_align_pipe_if.slave (operands in, aligned pair out,
//              valid/ready handshake on both sides)
module add_sub_align_pipe #(
  parameter int SIZE_EXP = 8,
  parameter int SIZE_MAN = 24
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  add_sub_align_pipe_if.slave bus
);
  localparam int W_EXT = SIZE_MAN + 2;
  localparam logic [SIZE_EXP:0] W_EXT_CMP = (SIZE_EXP+1)'(W_EXT);

  // Stage 1 registers
  logic                s1_valid;
  logic                s1_swap, s1_eff_sub, s1_sign;
  logic [SIZE_EXP-1:0] s1_exp_max, s1_diff;
  logic [SIZE_MAN-1:0] s1_man_max, s1_man_min;

  // Stage 2 registers (drive the outputs directly)
  logic                s2_valid;
  logic                s2_swap, s2_eff_sub, s2_sign;
  logic [SIZE_EXP-1:0] s2_exp_max;
  logic [SIZE_MAN-1:0] s2_man_max;
  logic [SIZE_MAN+2:0] s2_man_min;

  // A stage loads when empty or when its content leaves this cycle.
  logic s2_load, s1_load;
  assign s2_load = !s2_valid || bus.i_ready;
  assign s1_load = !s1_valid || s2_load;

  // Stage 1 compare / swap
  logic                cmp, sign_b_eff;
  logic [SIZE_EXP-1:0] exp_max, exp_min;
  assign cmp = (bus.i_exp_b > bus.i_exp_a) ||
               ((bus.i_exp_b == bus.i_exp_a) && (bus.i_man_b > bus.i_man_a));
  // Subtract folds into b's sign: a - b == a + (-b).
  assign sign_b_eff = bus.i_sign_b ^ bus.i_op;
  assign exp_max = cmp ? bus.i_exp_b : bus.i_exp_a;
  assign exp_min = cmp ? bus.i_exp_a : bus.i_exp_b;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid   <= 1'b0;
      s1_swap    <= 1'b0;
      s1_eff_sub <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp_max <= '0;
      s1_diff    <= '0;
      s1_man_max <= '0;
      s1_man_min <= '0;
    end else if (s1_load) begin
      s1_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s1_swap    <= cmp;
        s1_eff_sub <= bus.i_sign_a ^ sign_b_eff;
        s1_sign    <= cmp ? sign_b_eff : bus.i_sign_a;
        s1_exp_max <= exp_max;
        s1_diff    <= exp_max - exp_min;
        s1_man_max <= cmp ? bus.i_man_b : bus.i_man_a;
        s1_man_min <= cmp ? bus.i_man_a : bus.i_man_b;
      end
    end
  end

  // Stage 2 alignment: two extra LSBs become G and R; everything shifted
  // past them collapses into sticky.
  logic [W_EXT-1:0] ext, shifted, low_mask;
  logic             sticky;
  assign ext      = {s1_man_min, 2'b00};
  assign low_mask = ~({W_EXT{1'b1}} << s1_diff);

  always_comb begin
    shifted = '0;
    sticky  = 1'b0;
    if ({1'b0, s1_diff} >= W_EXT_CMP) begin
      shifted = '0;
      sticky  = |s1_man_min;
    end else begin
      shifted = ext >> s1_diff;
      sticky  = |(ext & low_mask);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_valid   <= 1'b0;
      s2_swap    <= 1'b0;
      s2_eff_sub <= 1'b0;
      s2_sign    <= 1'b0;
      s2_exp_max <= '0;
      s2_man_max <= '0;
      s2_man_min <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_swap    <= s1_swap;
        s2_eff_sub <= s1_eff_sub;
        s2_sign    <= s1_sign;
        s2_exp_max <= s1_exp_max;
        s2_man_max <= s1_man_max;
        s2_man_min <= {shifted, sticky};
      end
    end
  end

  assign bus.o_ready   = s1_load;
  assign bus.o_valid   = s2_valid;
  assign bus.o_swap    = s2_swap;
  assign bus.o_eff_sub = s2_eff_sub;
  assign bus.o_sign    = s2_sign;
  assign bus.o_exp_max = s2_exp_max;
  assign bus.o_man_max = s2_man_max;
  assign bus.o_man_min = s2_man_min;
endmodule

// File: tb/tb_add_sub_align_pipe.sv
// tb_add_sub_align_pipe
// Directed bench for add_sub_align_pipe: reset values, ordering/sign cases,
// alignment with sticky and full shift-out, backpressure and mid-stream reset.
module tb_add_sub_align_pipe;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  add_sub_align_pipe_if #(.SIZE_EXP(8), .SIZE_MAN(24)) bus ();

  add_sub_align_pipe #(.SIZE_EXP(8), .SIZE_MAN(24)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic op, input logic sa, input logic [7:0] ea, input logic [23:0] ma,
                        input logic sb, input logic [7:0] eb, input logic [23:0] mb);
    bus.i_op     = op;
    bus.i_sign_a = sa;
    bus.i_exp_a  = ea;
    bus.i_man_a  = ma;
    bus.i_sign_b = sb;
    bus.i_exp_b  = eb;
    bus.i_man_b  = mb;
  endtask

  // One isolated pair through an otherwise idle pipe with i_ready = 1.
  task automatic one_pair(input string tag,
                          input logic op, input logic sa, input logic [7:0] ea, input logic [23:0] ma,
                          input logic sb, input logic [7:0] eb, input logic [23:0] mb,
                          input logic swap, input logic eff, input logic sgn, input logic [7:0] emax,
                          input logic [23:0] mmax, input logic [26:0] mmin);
    set_in(op, sa, ea, ma, sb, eb, mb);
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    chk({tag, "_not_early"}, bus.o_valid, 1'b0);
    tick();
    chk({tag, "_valid"},   bus.o_valid,   1'b1);
    chk({tag, "_swap"},    bus.o_swap,    swap);
    chk({tag, "_eff_sub"}, bus.o_eff_sub, eff);
    chk({tag, "_sign"},    bus.o_sign,    sgn);
    chk({tag, "_exp_max"}, bus.o_exp_max, emax);
    chk({tag, "_man_max"}, bus.o_man_max, mmax);
    chk({tag, "_man_min"}, bus.o_man_min, mmin);
    tick();
    chk({tag, "_drained"}, bus.o_valid, 1'b0);
  endtask

  initial begin
    int sent, rcvd;
    n_chk  = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    set_in(1'b0, 1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 24'd0);
    tick();
    tick();
    chk("rst_o_valid", bus.o_valid, 1'b0);
    chk("rst_o_ready", bus.o_ready, 1'b1);
    chk("rst_man_min", bus.o_man_min, 27'd0);
    chk("rst_exp_max", bus.o_exp_max, 8'd0);
    rst_n = 1'b1;
    tick();

    // Basic alignment, diff 2
    one_pair("basic", 1'b0, 1'b0, 8'd130, 24'hC00000, 1'b0, 8'd128, 24'h800000,
             1'b0, 1'b0, 1'b0, 8'd130, 24'hC00000, 27'h1000000);
    // b larger by exponent, subtract: eff_sub and sign from negated b
    one_pair("swapsub", 1'b1, 1'b0, 8'd100, 24'h800000, 1'b0, 8'd101, 24'h800000,
             1'b1, 1'b1, 1'b1, 8'd101, 24'h800000, 27'h2000000);
    // Equal exponents, b wins on mantissa
    one_pair("eqexp", 1'b0, 1'b0, 8'd120, 24'h900000, 1'b0, 8'd120, 24'hA00000,
             1'b1, 1'b0, 1'b0, 8'd120, 24'hA00000, 27'h4800000);
    // Exact tie: a stays max, no shift
    one_pair("tie", 1'b0, 1'b1, 8'd120, 24'hB00000, 1'b1, 8'd120, 24'hB00000,
             1'b0, 1'b0, 1'b1, 8'd120, 24'hB00000, 27'h5800000);
    // diff 3: the LSB falls into sticky
    one_pair("sticky3", 1'b0, 1'b0, 8'd50, 24'hFFFFFF, 1'b0, 8'd47, 24'h800001,
             1'b0, 1'b0, 1'b0, 8'd50, 24'hFFFFFF, 27'h0800001);
    // diff 40: everything shifted out, only sticky survives
    one_pair("shift40", 1'b0, 1'b1, 8'd10, 24'h800001, 1'b0, 8'd50, 24'hC00000,
             1'b1, 1'b1, 1'b0, 8'd50, 24'hC00000, 27'h0000001);

    // Backpressure: 5 pairs back-to-back, i_ready low in cycles 2..5.
    // Pair k: a = (exp 60+k, man C00000), b = (exp 60, man 800000) -> exp_max 60+k.
    sent = 0;
    rcvd = 0;
    for (int c = 0; c < 20; c++) begin
      bus.i_ready = (c >= 2 && c <= 5) ? 1'b0 : 1'b1;
      bus.i_valid = (sent < 5) ? 1'b1 : 1'b0;
      set_in(1'b0, 1'b0, 8'(60 + sent), 24'hC00000, 1'b0, 8'd60, 24'h800000);
      #1;
      if (c >= 2 && c <= 5) chk("bp_ready_low", bus.o_ready, 1'b0);
      if (c < 2) chk("bp_ready_high", bus.o_ready, 1'b1);
      if (bus.o_valid) begin
        chk("bp_order_exp", bus.o_exp_max, 8'(60 + rcvd));
        chk("bp_swap", bus.o_swap, 1'b0);
      end
      if (bus.o_valid && bus.i_ready) rcvd++;
      if (bus.i_valid && bus.o_ready) sent++;
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    chk("bp_sent", 32'(sent), 32'd5);
    chk("bp_rcvd", 32'(rcvd), 32'd5);
    chk("bp_idle", bus.o_valid, 1'b0);

    // Mid-stream reset with two pairs in flight
    bus.i_ready = 1'b0;
    set_in(1'b1, 1'b1, 8'd90, 24'hF00000, 1'b0, 8'd95, 24'hE00000);
    bus.i_valid = 1'b1;
    tick();
    set_in(1'b1, 1'b1, 8'd91, 24'hF00000, 1'b0, 8'd96, 24'hE00000);
    tick();
    bus.i_valid = 1'b0;
    chk("mr_full_valid", bus.o_valid, 1'b1);
    chk("mr_full_ready", bus.o_ready, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("mr_o_valid", bus.o_valid, 1'b0);
    chk("mr_o_ready", bus.o_ready, 1'b1);
    chk("mr_swap", bus.o_swap, 1'b0);
    chk("mr_sign", bus.o_sign, 1'b0);
    chk("mr_eff_sub", bus.o_eff_sub, 1'b0);
    chk("mr_exp_max", bus.o_exp_max, 8'd0);
    chk("mr_man_max", bus.o_man_max, 24'd0);
    chk("mr_man_min", bus.o_man_min, 27'd0);
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mr_no_ghost", bus.o_valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/add_sub_align_pipe.md
# add_sub_align_pipe

Pipelined operand-ordering and mantissa-alignment front end for the FPU add/sub datapath. It sits between operand unpack and the mantissa adder. Each cycle it can accept one operand pair and performs these steps:
- compares magnitudes across exponent and mantissa;
- swaps the operands so the larger one is first;
- resolves the effective operation and result sign;
- right-shifts the smaller mantissa by the exponent difference, producing guard, round and sticky bits.

It extends the single-cycle combinational swap with full magnitude comparison, alignment, and a two-stage valid/ready pipeline with backpressure.

## Interface
Parameters:
- SIZE_EXP, default 8: exponent width (biased).
- SIZE_MAN, default 24: mantissa width, hidden bit included.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_valid  in  1  input operand pair valid.
- o_ready  out  1  block can accept an input this cycle.
- i_op  in  1  0 = add, 1 = subtract (a − b).
- i_sign_a, i_sign_b  in  1 each  operand signs.
- i_exp_a, i_exp_b  in  SIZE_EXP each  biased exponents.
- i_man_a, i_man_b  in  SIZE_MAN each  mantissas.
- o_valid  out  1  output result valid.
- i_ready  in  1  downstream accepts the output this cycle.
- o_swap  out  1  1 when operand b was selected as max.
- o_eff_sub  out  1  effective subtraction: i_sign_a ^ i_sign_b ^ i_op.
- o_sign  out  1  sign of the max operand; b's sign is taken as i_sign_b ^ i_op.
- o_exp_max  out  SIZE_EXP  exponent of the max operand.
- o_man_max  out  SIZE_MAN  mantissa of the max operand.
- o_man_min  out  SIZE_MAN+3  aligned min mantissa: {shifted mantissa, G, R, S}.

## Operation
- Transfer rules:
  - An input transfer occurs when i_valid && o_ready.
  - An output transfer occurs when o_valid && i_ready.
- Stage 1 (compare/swap), registered:
  - compare = (exp_b > exp_a) || (exp_b == exp_a && man_b > man_a).
  - Equal magnitudes give compare = 0, so a is max.
  - Stage 1 registers max/min exponent, max/min mantissa, o_swap, o_eff_sub, o_sign, and diff = exp_max − exp_min (unsigned, SIZE_EXP bits, never negative).
- Stage 2 (align), registered:
  - ext = {man_min, 2'b00}, width SIZE_MAN+2.
  - shifted = ext >> diff.
  - S = OR of every ext bit shifted below position 0.
  - o_man_min = {shifted, S}.
  - If diff ≥ SIZE_MAN+2: shifted = 0 and S = |man_min.
  - If diff = 0: o_man_min = {man_min, 3'b000}.
- Stage 2 passes all other fields through unchanged.
- No exception handling (NaN, Inf, denormals); zero operands go through the normal path.
- Pipeline control:
  - Each stage holds a valid bit.
  - A stage loads when it is empty or its content is leaving this cycle.
  - stage2_load = !s2_valid || i_ready.
  - o_ready = !s1_valid || stage2_load.
  - o_valid = s2_valid.
  - Data registers load only on a load enable; otherwise they hold.

## Timing
- Latency is 2 cycles. A pair accepted at edge N appears on outputs after edge N+1, available for transfer in cycle N+2.
- Throughput is 1 pair per cycle while i_ready stays 1.
- o_ready is combinational from i_ready (no skid buffer). The 2-entry pipeline fills fully under backpressure.
- While o_valid = 1 and i_ready = 0, every output holds stable.
- Reset, when i_rst_n is low at an edge:
  - s1_valid, s2_valid, o_valid go to 0;
  - all data registers, o_swap, o_eff_sub and o_sign go to 0;
  - o_ready = 1 from the first cycle after reset.
- Reset mid-operation discards in-flight pairs with no partial output.
- Simultaneous input and output transfer on a full pipeline is allowed: both stages advance in the same cycle with no bubble.

## Test plan
- Basic align, i_ready = 1:
  - stimulus: a = (exp 130, man 24'hC00000), b = (exp 128, man 24'h800000), op = 0, signs 0.
  - response after 2 cycles: o_swap = 0, o_exp_max = 130, o_man_max = 24'hC00000, o_man_min = 27'h1000000, o_eff_sub = 0, o_sign = 0.
- Swap with subtract:
  - stimulus: a = (exp 100, man 24'h800000, sign 0), b = (exp 101, man 24'h800000, sign 0), op = 1.
  - response: o_swap = 1, o_eff_sub = 1, o_sign = 1, o_exp_max = 101, o_man_min = 27'h2000000.
- Equal exponents decided by mantissa, then exact tie:
  - stimulus: man_b = 24'hA00000 > man_a = 24'h900000 → o_swap = 1.
  - stimulus: identical operands → o_swap = 0, diff 0, o_man_min = {man, 3'b000}.
- Sticky and full shift-out, each with man_min = 24'h800001:
  - diff 3 → o_man_min = 27'h0800001.
  - diff 40 → o_man_min = 27'h0000001.
- Backpressure:
  - stimulus: stream 5 pairs back-to-back; hold i_ready = 0 for cycles 2–5.
  - response: o_ready drops after 2 pairs are buffered; outputs stable while stalled; all 5 pairs emerge in order with no loss or duplication.
- Reset mid-stream:
  - stimulus: assert i_rst_n = 0 with 2 pairs in flight.
  - response: the next cycle shows o_valid = 0, all outputs 0, o_ready = 1; none of the discarded pairs is ever output.
